// File: rtl/echo_energy_detect.sv
// Echo detector: after each transmit burst, skips a blanking interval, finds the first
// sustained threshold crossing and the echo peak, and returns one result record per burst.
module echo_energy_detect #(
  parameter int unsigned ENERGY_W = 24,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                SYS_CLK,
  input  logic                RESET,
  input  logic                start,
  input  logic                energyValid,
  input  logic [ENERGY_W-1:0] inEnergy,
  input  logic [ENERGY_W-1:0] threshold,
  input  logic [CNT_W-1:0]    blankSamples,
  input  logic [CNT_W-1:0]    windowSamples,
  input  logic [3:0]          holdCount,
  output logic                busy,
  output logic                echoValid,
  output logic                echoFound,
  output logic [CNT_W-1:0]    tofSamples,
  output logic [ENERGY_W-1:0] peakEnergy,
  output logic [CNT_W-1:0]    peakIndex
);

  typedef enum logic [2:0] {IDLE, BLANK, SEARCH, TRACK, DONE} state_t;

  state_t              state;
  logic [ENERGY_W-1:0] thr_q;
  logic [CNT_W-1:0]    blank_q;
  logic [CNT_W-1:0]    win_q;
  logic [3:0]          hold_q;
  logic [CNT_W-1:0]    k;
  logic [3:0]          run_len;
  logic [CNT_W-1:0]    run_start;
  logic [CNT_W-1:0]    cur_tof;
  logic [ENERGY_W-1:0] cur_peak;
  logic [CNT_W-1:0]    cur_pidx;

  logic                above;
  logic                win_end;
  logic                blank_end;
  logic                hit;
  logic                peak_upd;
  logic [CNT_W-1:0]    k_next;
  logic [CNT_W-1:0]    run_first;
  logic [CNT_W-1:0]    pidx_n;
  logic [ENERGY_W-1:0] peak_n;

  // Per-sample evaluation of the current strobe against the latched configuration.
  always_comb begin
    above     = inEnergy > thr_q;
    win_end   = k == win_q - CNT_W'(1);
    blank_end = k == blank_q - CNT_W'(1);
    hit       = above && (run_len >= hold_q - 4'd1);
    run_first = (run_len == 4'd0) ? k : run_start;
    peak_upd  = inEnergy > cur_peak;
    peak_n    = peak_upd ? inEnergy : cur_peak;
    pidx_n    = peak_upd ? k : cur_pidx;
    k_next    = (k == '1) ? k : k + CNT_W'(1);
  end

  // Capture sequencer; result outputs only change on start and on entry to DONE.
  always_ff @(posedge SYS_CLK) begin
    if (RESET) begin
      state      <= IDLE;
      thr_q      <= '0;
      blank_q    <= '0;
      win_q      <= '0;
      hold_q     <= '0;
      k          <= '0;
      run_len    <= '0;
      run_start  <= '0;
      cur_tof    <= '0;
      cur_peak   <= '0;
      cur_pidx   <= '0;
      busy       <= 1'b0;
      echoValid  <= 1'b0;
      echoFound  <= 1'b0;
      tofSamples <= '0;
      peakEnergy <= '0;
      peakIndex  <= '0;
    end else begin
      echoValid <= 1'b0;
      if (start) begin
        thr_q      <= threshold;
        blank_q    <= blankSamples;
        win_q      <= windowSamples;
        hold_q     <= (holdCount == 4'd0) ? 4'd1 : holdCount;
        k          <= '0;
        run_len    <= '0;
        run_start  <= '0;
        cur_tof    <= '1;
        cur_peak   <= '0;
        cur_pidx   <= '0;
        busy       <= 1'b1;
        echoFound  <= 1'b0;
        tofSamples <= '1;
        peakEnergy <= '0;
        peakIndex  <= '0;
        if (windowSamples == '0) begin
          state     <= DONE;
          echoValid <= 1'b1;
        end else if (blankSamples == '0) begin
          state <= SEARCH;
        end else begin
          state <= BLANK;
        end
      end else begin
        case (state)
          IDLE: ;
          BLANK: begin
            if (energyValid) begin
              k <= k_next;
              if (win_end) begin
                state     <= DONE;
                echoValid <= 1'b1;
              end else if (blank_end) begin
                state <= SEARCH;
              end
            end
          end
          SEARCH: begin
            if (energyValid) begin
              k        <= k_next;
              cur_peak <= peak_n;
              cur_pidx <= pidx_n;
              if (above) begin
                run_len <= run_len + 4'd1;
                if (run_len == 4'd0) run_start <= k;
              end else begin
                run_len <= '0;
              end
              if (hit) begin
                cur_tof <= run_first;
                state   <= TRACK;
              end
              if (win_end) begin
                state      <= DONE;
                echoValid  <= 1'b1;
                echoFound  <= hit;
                tofSamples <= hit ? run_first : '1;
                peakEnergy <= peak_n;
                peakIndex  <= pidx_n;
              end
            end
          end
          TRACK: begin
            if (energyValid) begin
              k        <= k_next;
              cur_peak <= peak_n;
              cur_pidx <= pidx_n;
              if (!above || win_end) begin
                state      <= DONE;
                echoValid  <= 1'b1;
                echoFound  <= 1'b1;
                tofSamples <= cur_tof;
                peakEnergy <= peak_n;
                peakIndex  <= pidx_n;
              end
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/echo_energy_detect.md
# echo_energy_detect

Downstream consumer of the sliding-window sum-of-squares energy stage in the ultrasonic receive chain. After each transmit burst it counts energy samples, ignores a blanking interval, then finds the first sustained threshold crossing (time-of-flight in samples) and the peak energy of the echo. It returns one result record per burst with a single-cycle valid pulse, for the ranging/host-interface logic.

## Interface
- ENERGY_W, 24, width of energy input, threshold and peak
- CNT_W, 16, width of sample index, blanking, window and time-of-flight fields
- SYS_CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse marking transmit burst fired; begins a capture
- energyValid  in  1  strobe: inEnergy holds a new sample this cycle (upstream sample strobe delayed one cycle)
- inEnergy  in  ENERGY_W  unsigned energy sample from sum-of-squares stage
- threshold  in  ENERGY_W  unsigned detection threshold; sampled at start
- blankSamples  in  CNT_W  samples ignored after start; sampled at start
- windowSamples  in  CNT_W  total capture length in samples (index limit); sampled at start
- holdCount  in  4  consecutive above-threshold samples required; 0 treated as 1; sampled at start
- busy  out  1  high from cycle after start until return to IDLE
- echoValid  out  1  one-cycle pulse: result fields valid
- echoFound  out  1  1 = crossing detected in window
- tofSamples  out  CNT_W  index of first sample of qualifying run; all-ones if none
- peakEnergy  out  ENERGY_W  maximum inEnergy over evaluated samples
- peakIndex  out  CNT_W  index of first occurrence of peakEnergy

## Operation
- Sample index k: k-th energyValid after start, first = 0; internal counter, saturates at all-ones.
- States: IDLE, BLANK, SEARCH, TRACK, DONE.
- IDLE: start → latch config, k=0, clear run/peak, go BLANK (SEARCH if blankSamples=0).
- BLANK: samples k < blankSamples ignored; on sample k = blankSamples−1 go SEARCH.
- SEARCH: evaluate each sample; above = inEnergy > threshold (strict). Run length increments on above, clears otherwise; run start index recorded on first above sample. Run reaching effective holdCount → echoFound=1, tofSamples=run start, go TRACK.
- TRACK: evaluate samples; first sample with inEnergy ≤ threshold → DONE.
- Peak: every evaluated sample (SEARCH and TRACK) with inEnergy > current peak updates peakEnergy/peakIndex (strict, earliest kept).
- Window end: evaluated sample k = windowSamples−1 processed (including its peak/detection update) → DONE from SEARCH or TRACK. windowSamples ≤ blankSamples: BLANK goes DONE at k = windowSamples−1 (or immediately if windowSamples=0) with echoFound=0, peak 0.
- No detection: echoFound=0, tofSamples=all ones.
- DONE: echoValid=1 for one cycle, → IDLE. Result fields hold until next start.
- start while busy: abort, restart capture from new config; no echoValid for aborted capture.
- start and energyValid same cycle: that sample is not counted.

## Timing
- Reset: state IDLE, busy=0, echoValid=0, echoFound=0, tofSamples=0, peakEnergy=0, peakIndex=0, counters 0.
- start at cycle t → busy=1 at t+1.
- Final qualifying/terminating sample at cycle t → DONE at t+1, echoValid=1 and result fields updated at t+1, busy=0 at t+2.
- Outputs registered; no combinational input→output paths.
- RESET mid-capture overrides everything that cycle; no echoValid.
- energyValid may be any duty cycle including every cycle; gaps do not advance k.
- Result fields cleared on start (echoFound=0, tofSamples=all ones, peak 0) at t+1.

## Test plan
- Reset mid-capture: start, 5 samples, RESET → all outputs 0, IDLE, no echoValid; next start works normally.
- Basic echo: threshold=1000, blank=10, window=100, hold=3; energy 0 except k=40..49 = 5000, k=45 = 8000 → echoFound=1, tof=40, peak=8000, peakIndex=45, echoValid one cycle after k=50 sample.
- Blanking/hold: energy 9000 at k=0..9 and 2000 at k=20,21 only, hold=3 → echoFound=0, tof=0xFFFF, peak=2000, peakIndex=20, echoValid after k=99.
- Threshold equality and hold=0: energy exactly 1000 at k=15, 1001 at k=16, hold=0 → tof=16.
- Window cutoff during TRACK: window=50, energy 3000 from k=45 onward, hold=1 → tof=45, DONE after k=49, peakIndex=45.
- Abort/gapped strobe: energyValid every 3rd cycle, start reissued during SEARCH → only second capture produces echoValid; indices counted per strobe not per cycle.
